// File: rtl/hififo_pkg.sv
// Shared definitions for the hififo arbiters: FSM state encoding, burst
// geometry and a small index-wrap helper.
package hififo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } hififo_state_t;

  localparam int HIFIFO_BURST_WORDS = 16;
  localparam int HIFIFO_WORD_BITS   = 64;

  // Wrap a channel index into 0..n-1.
  function automatic int hififo_wrap(input int idx, input int n);
    return idx % n;
  endfunction

endpackage

// File: rtl/hififo_rr_pick.sv
// Combinational round-robin picker: searches i_req starting one above
// i_last (wrapping modulo NCH) and returns the first requester found.
// Passing i_last = NCH-1 turns it into a lowest-index-first picker.
module hififo_rr_pick
  import hififo_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] i_req,
  input  logic [2:0]     i_last,
  output logic [2:0]     o_next,
  output logic           o_found
);

  // Walk NCH candidates after i_last; the first hit wins.
  always_comb begin
    o_next  = i_last;
    o_found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      int k;
      k = hififo_wrap(int'(i_last) + i, NCH);
      if (!o_found && |(i_req & (NCH'(1) << k))) begin
        o_found = 1'b1;
        o_next  = 3'(k);
      end
    end
  end

endmodule

// File: rtl/hififo_tpc_arbiter.sv
// Shares one posted-write request path among NCH TPC FIFO channels.
// A grant is locked for a whole BURST-word transfer so addr/data of
// different channels never interleave. Arbitration is round-robin by
// default; defining HIFIFO_ARB_PRIORITY_EN selects fixed lowest-index
// priority instead (burst locking, latency and gap are unchanged).
module hififo_tpc_arbiter
  import hififo_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int BURST = HIFIFO_BURST_WORDS
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NCH-1:0]                  ch_enable,
  input  logic [NCH-1:0]                  in_valid,
  input  logic [HIFIFO_WORD_BITS*NCH-1:0] in_addr,
  input  logic [HIFIFO_WORD_BITS*NCH-1:0] in_data,
  output logic [NCH-1:0]                  in_ready,
  output logic                            out_valid,
  output logic [HIFIFO_WORD_BITS-1:0]     out_addr,
  output logic [HIFIFO_WORD_BITS-1:0]     out_data,
  input  logic                            out_ready,
  output logic [2:0]                      grant,
  output logic                            busy,
  output logic                            err_spurious
);

  localparam int WB = HIFIFO_WORD_BITS;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  hififo_state_t  r_state;
  logic [2:0]     r_grant;
  logic [BW-1:0]  r_beat;
  logic           r_err;

  logic [NCH-1:0] w_req;
  logic [2:0]     w_last;
  logic [2:0]     w_pick;
  logic           w_found;
  logic [WB-1:0]  w_addr [NCH];
  logic [WB-1:0]  w_data [NCH];

  assign w_req = in_valid & ch_enable;

`ifdef HIFIFO_ARB_PRIORITY_EN
  // Searching from NCH-1 upward always starts at channel 0.
  assign w_last = 3'(NCH - 1);
`else
  assign w_last = r_grant;
`endif

  hififo_rr_pick #(.NCH(NCH)) u_pick (
    .i_req   (w_req),
    .i_last  (w_last),
    .o_next  (w_pick),
    .o_found (w_found)
  );

  // Unpack the per-channel address and data lanes.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
      assign w_addr[gi] = in_addr[gi*WB +: WB];
      assign w_data[gi] = in_data[gi*WB +: WB];
    end
  endgenerate

  // Arbitration FSM: pick in IDLE, count accepted words in BURST.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= 3'(NCH - 1);
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (out_ready && r_state != ST_BURST) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_beat  <= '0;
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Readies count even with valid low: channels drop valid
          // after their first accepted word.
          if (out_ready) begin
            if (r_beat == BW'(BURST - 1)) begin
              r_beat  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Route the granted channel through; everything is quiet outside BURST.
  always_comb begin
    out_valid = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    in_ready  = '0;
    if (r_state == ST_BURST) begin
      for (int k = 0; k < NCH; k++) begin
        if (r_grant == 3'(k)) begin
          out_valid   = in_valid[k];
          out_addr    = w_addr[k];
          out_data    = w_data[k];
          in_ready[k] = out_ready;
        end
      end
    end
  end

  assign grant        = r_grant;
  assign busy         = (r_state == ST_BURST);
  assign err_spurious = r_err;

endmodule

// File: tb/tb_hififo_tpc_arbiter.sv
module tb_hififo_tpc_arbiter;

  localparam int NCH   = 4;
  localparam int BURST = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    ch_enable;
  logic [NCH-1:0]    in_valid;
  logic [64*NCH-1:0] in_addr;
  logic [64*NCH-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [63:0]       out_addr;
  logic [63:0]       out_data;
  logic              out_ready;
  logic [2:0]        grant;
  logic              busy;
  logic              err_spurious;

  always #5 clock = ~clock;

  hififo_tpc_arbiter #(.NCH(NCH), .BURST(BURST)) dut (
    .clock        (clock),
    .reset        (reset),
    .ch_enable    (ch_enable),
    .in_valid     (in_valid),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .grant        (grant),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  // Channel models: valid+addr held until first ready, 16 words each.
  logic [NCH-1:0] v_valid;
  logic [NCH-1:0] v_repeat;
  logic [NCH-1:0] v_enable;
  logic [63:0]    v_addr [NCH];
  int             v_word [NCH];

  assign in_valid  = v_valid;
  assign ch_enable = v_enable;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign in_addr[64*gi +: 64] = v_addr[gi];
      assign in_data[64*gi +: 64] = v_addr[gi] + 64'(v_word[gi]) + 64'h5A5A_0000_0000_0000;
    end
  endgenerate

  int   total = 0;
  int   bad   = 0;
  int   exp_q [$];
  int   cur, beats, nb, idle_run;
  logic prev_busy;

  typedef struct {
    logic [3:0]      valid;
    logic [3:0]      en;
    logic [3:0]      rep;
    int              n;
    int              min_cyc;
    logic [4:0][2:0] ord;
  } vec_t;

  vec_t vt [6];

  function automatic vec_t mk(logic [3:0] va, logic [3:0] en, logic [3:0] rp, int n, int mc,
                              int o0, int o1, int o2, int o3, int o4);
    vec_t v;
    v.valid = va; v.en = en; v.rep = rp; v.n = n; v.min_cyc = mc;
    v.ord[0] = 3'(o0); v.ord[1] = 3'(o1); v.ord[2] = 3'(o2);
    v.ord[3] = 3'(o3); v.ord[4] = 3'(o4);
    return v;
  endfunction

  function automatic logic [63:0] data_of(int k);
    return v_addr[k] + 64'(v_word[k]) + 64'h5A5A_0000_0000_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic init_ch();
    for (int k = 0; k < NCH; k++) begin
      v_word[k] = 0;
      v_addr[k] = (k == 0) ? 64'h0000_0000_0000_F000 : 64'h1000 * 64'(k);
    end
    v_valid  = '0;
    v_repeat = '0;
    v_enable = '1;
  endtask

  task automatic clear_book();
    prev_busy = 1'b0; beats = 0; nb = 0; idle_run = 0; cur = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    init_ch();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    clear_book();
    @(negedge clock);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'(NCH - 1));
    chk("rst_err",   64'(err_spurious), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
  endtask

  // One clock: check at negedge, then update channel models after the edge.
  task automatic cyc();
    logic [NCH-1:0] seen;
    logic [NCH-1:0] e;
    @(negedge clock);
    seen = in_ready;
    if (busy && !prev_busy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL grant_order: got %0d want no grant", grant);
        cur = int'(grant);
      end else begin
        cur = exp_q.pop_front();
        chk("grant_order", 64'(grant), 64'(cur));
      end
      chk("burst_addr", out_addr, v_addr[cur]);
      if (nb > 0) chk("burst_gap", 64'(idle_run), 64'd1);
      $display("burst %0d: grant=%0d addr=%h", nb, grant, out_addr);
      nb++;
      beats = 0;
      idle_run = 0;
    end
    if (!busy && prev_busy) chk("burst_len", 64'(beats), 64'(BURST));
    if (busy) begin
      e = '0;
      if (out_ready) e[cur] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(e));
      chk("out_valid", 64'(out_valid), 64'(v_valid[cur]));
      chk("out_data", out_data, data_of(cur));
      if (out_ready) beats++;
    end else begin
      idle_run++;
      chk("idle_quiet", 64'({out_valid, in_ready}) | out_addr | out_data, 64'd0);
    end
    prev_busy = busy;
    @(posedge clock);
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (seen[k]) begin
        v_word[k]++;
        v_valid[k] = 1'b0;
        if (v_word[k] == BURST) begin
          v_word[k] = 0;
          v_addr[k] = v_addr[k] + 64'd128;
          if (v_repeat[k]) v_valid[k] = 1'b1;
        end
      end
    end
    out_ready = busy ? ($urandom_range(0, 3) != 0) : 1'b0;
  endtask

  // Run until the expected grants are consumed and the arbiter settles.
  task automatic run_vec(input int min_cyc, input int raise_beat);
    bit withdrawn = 0;
    bit raised = 0;
    bit done = 0;
    int tail = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      cyc();
      if (raise_beat >= 0 && !raised && busy && cur == 0 && beats >= raise_beat) begin
        v_valid[2]  = 1'b1;
        v_enable[0] = 1'b0;
        raised = 1;
      end
      if (!withdrawn && exp_q.size() == 0 && c >= min_cyc) begin
        withdrawn = 1;
        v_repeat = '0;
        for (int k = 0; k < NCH; k++)
          if (!(busy && k == cur)) v_valid[k] = 1'b0;
      end
      if (withdrawn) begin
        if (busy) tail = 0;
        else tail++;
        if (tail >= 4) done = 1;
      end
    end
    chk("vec_done", 64'(done), 64'd1);
    chk("queue_left", 64'(exp_q.size()), 64'd0);
    chk("no_spurious", 64'(err_spurious), 64'd0);
  endtask

  initial begin
    out_ready = 1'b0;
    init_ch();
    clear_book();

`ifdef HIFIFO_ARB_PRIORITY_EN
    vt[0] = mk(4'b0010, 4'b1111, 4'b0000, 1, 0,  1, 0, 0, 0, 0);
    vt[1] = mk(4'b1111, 4'b1111, 4'b1111, 5, 0,  0, 0, 0, 0, 0);
    vt[2] = mk(4'b1010, 4'b1111, 4'b1010, 4, 0,  1, 1, 1, 1, 0);
    vt[3] = mk(4'b1111, 4'b0101, 4'b1111, 3, 0,  0, 0, 0, 0, 0);
    vt[4] = mk(4'b0100, 4'b1011, 4'b0000, 0, 40, 0, 0, 0, 0, 0);
    vt[5] = mk(4'b0110, 4'b1111, 4'b0000, 2, 0,  1, 2, 0, 0, 0);
`else
    vt[0] = mk(4'b0010, 4'b1111, 4'b0000, 1, 0,  1, 0, 0, 0, 0);
    vt[1] = mk(4'b1111, 4'b1111, 4'b1111, 5, 0,  0, 1, 2, 3, 0);
    vt[2] = mk(4'b1010, 4'b1111, 4'b1010, 4, 0,  1, 3, 1, 3, 0);
    vt[3] = mk(4'b1111, 4'b0101, 4'b1111, 3, 0,  0, 2, 0, 0, 0);
    vt[4] = mk(4'b0100, 4'b1011, 4'b0000, 0, 40, 0, 0, 0, 0, 0);
    vt[5] = mk(4'b0110, 4'b1111, 4'b0000, 2, 0,  1, 2, 0, 0, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      do_reset();
      v_valid  = vt[i].valid;
      v_enable = vt[i].en;
      v_repeat = vt[i].rep;
      for (int j = 0; j < vt[i].n; j++) exp_q.push_back(int'(vt[i].ord[j]));
      run_vec(vt[i].min_cyc, -1);
    end

    // Lock: ch2 requests (and ch0 is disabled) mid-burst of ch0.
    do_reset();
    v_valid = 4'b0001;
    exp_q.push_back(0);
    exp_q.push_back(2);
    run_vec(0, 5);

    // Reset in the middle of a burst.
    do_reset();
    v_valid  = 4'b0001;
    v_repeat = 4'b0001;
    exp_q.push_back(0);
    begin
      int c = 0;
      while (!(busy && beats >= 7) && c < 200) begin
        cyc();
        c++;
      end
      chk("reach_beat7", 64'(c < 200), 64'd1);
    end
    reset = 1'b1;
    out_ready = 1'b0;
    init_ch();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy",  64'(busy), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd3);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    clear_book();
    v_valid = 4'b0011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    run_vec(0, -1);

    // Stray ready in IDLE sets a sticky error and reaches no channel.
    do_reset();
    out_ready = 1'b1;
    @(negedge clock);
    chk("spur_in_ready", 64'(in_ready), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);
    @(posedge clock);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("spur_sticky", 64'(err_spurious), 64'd1);
      chk("spur_quiet", 64'(in_ready), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hififo_tpc_arbiter.md
Name: hififo_tpc_arbiter

Overview:
- Shares one PCIe posted-write request path among NCH hififo TPC FIFO channels.
- Each channel presents a 128-byte burst request: valid and addr are held until the first ready, and 16 data words are transferred with one ready pulse per word.
- The arbiter grants one channel at a time, round-robin, and locks the grant for a full burst so that addr and data never interleave.
- It sits between the TPC FIFO channels and the PCIe TX request mux.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- BURST, 16, data words (64-bit) per request; must be a power of 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ch_enable  input  NCH  per-channel arbitration enable; a disabled channel is never granted.
- in_valid  input  NCH  per-channel burst request (wr_valid).
- in_addr  input  64*NCH  per-channel burst byte address; channel k occupies bits [64k+63:64k].
- in_data  input  64*NCH  per-channel write data, packed the same way as in_addr.
- in_ready  output  NCH  per-channel word-accept strobe (wr_ready).
- out_valid  output  1  granted request valid.
- out_addr  output  64  granted address.
- out_data  output  64  granted data.
- out_ready  input  1  downstream word-accept strobe.
- grant  output  3  index of the granted or last-granted channel.
- busy  output  1  high while in BURST.
- err_spurious  output  1  sticky flag: out_ready seen while not in BURST.

Behaviour:
- States:
  - IDLE: no channel granted.
  - BURST: a channel is granted and its burst is in progress.
- Reset values:
  - state = IDLE; grant = NCH-1, so channel 0 wins the first arbitration.
  - beat count = 0; busy = 0; err_spurious = 0.
  - in_ready = 0; out_valid = 0.
  - Reset asserted mid-burst aborts the burst immediately. No recovery of the partial burst; the channel FIFOs are reset together with the arbiter.
- IDLE arbitration:
  - Requesters are req = in_valid & ch_enable.
  - If req is nonzero, pick the first set bit searching from grant+1 upward, modulo NCH.
  - Register the winner into grant, clear the beat count, and enter BURST on the next edge.
  - Latency: one cycle from req to out_valid.
- BURST:
  - out_valid = in_valid[grant].
  - out_addr = in_addr[grant] and out_data = in_data[grant]. This mux is combinational, driven by the registered grant only.
  - in_ready[grant] = out_ready; all other in_ready bits = 0.
  - Each out_ready increments the beat count, whether or not out_valid is high, because a channel drops valid after the first ready.
  - When out_ready arrives with beat count = BURST-1, return to IDLE and clear the count.
- Outside BURST:
  - out_valid = 0, out_addr = 0, out_data = 0.
  - All in_ready bits = 0.
- Gap between bursts: exactly one IDLE cycle. The new burst's out_valid can first assert two cycles after the last out_ready.
- ch_enable changes:
  - Sampled only at arbitration.
  - Deasserting ch_enable for the granted channel mid-burst does not abort the burst.
- Simultaneous requests: the round-robin pointer guarantees each requesting channel a grant within NCH bursts.
- Width rules:
  - Beat counter width is log2(BURST).
  - grant is zero-extended to 3 bits.
- err_spurious:
  - Set when out_ready = 1 while state ≠ BURST.
  - Cleared only by reset.
  - The stray ready is not routed to any channel.

Optional Feature:
- Macro: HIFIFO_ARB_PRIORITY_EN.
- Defined: fixed priority; the lowest-index requesting channel always wins, and the round-robin pointer is unused.
- Undefined: round-robin as above.
- Burst locking, latency and the gap behaviour are identical in both modes.

Decomposition:
- Package hififo_pkg holds:
  - the state encoding constants ST_IDLE and ST_BURST;
  - HIFIFO_BURST_WORDS = 16;
  - HIFIFO_WORD_BITS = 64.
- One sub-module: hififo_rr_pick. It is combinational and takes a request vector plus the last grant, returning the next grant index and a found flag. It is reused by other hififo arbiters.

Test Plan:
- Single channel: ch1 raises valid with addr 0x1000, and downstream gives 16 readies one per cycle.
  - Expect out_addr = 0x1000 and in_ready[1] pulsed 16 times.
  - Expect a return to IDLE and busy falling after ready #16.
- All four channels valid at once after reset:
  - Expect grant order 0,1,2,3,0.
  - Each burst is 16 beats, with one IDLE cycle between bursts.
- Lock: ch0 in BURST and ch2 raises valid at beat 5.
  - Expect no switch to ch2 until beat 16 of ch0.
  - Expect in_ready[2] to stay 0 throughout ch0's burst.
- Reset mid-burst at beat 7:
  - Next cycle expect state IDLE, out_valid 0, grant 3.
  - After reset, ch0 is granted first.
- Spurious ready: out_ready pulsed in IDLE.
  - Expect err_spurious = 1 and sticky.
  - Expect no in_ready pulse on any channel.
- With HIFIFO_ARB_PRIORITY_EN and channels 1 and 3 continuously valid:
  - Expect ch1 granted every time; ch3 is never granted while ch1 requests.
